// File: rtl/stepper_multi_axis.sv
// stepper_multi_axis: multi-channel step/direction generator for A4988-class drivers.
//
// Each channel takes a move command (direction, step count, half-period) over a
// valid/ready handshake. It drives DIR, waits DIR_SETUP cycles, emits the requested
// number of STEP pulses (high for half cycles, low for half cycles) and then strobes
// done for one cycle. Channels are fully independent and share only clock and reset.
//
// Ports (all per-channel vectors are NUM_CH wide, bit i = channel i):
//   CLOCK_50   system clock
//   reset      synchronous, active-high reset
//   cmd_valid  command valid
//   cmd_ready  command ready (high in IDLE, low during reset)
//   cmd_dir    requested direction, 1 = CW
//   cmd_steps  step counts, channel i at [i*COUNT_W +: COUNT_W]
//   cmd_half   half-periods in cycles, channel i at [i*HALF_W +: HALF_W] (0 acts as 1)
//   abort      level-sensitive abort request
//   dir        driver DIR pin
//   step       driver STEP pin (registered)
//   en_n       driver ENABLE pin, active-low
//   busy       channel executing a move
//   done       one-cycle strobe on normal completion
module stepper_multi_axis #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned COUNT_W   = 16,
  parameter int unsigned HALF_W    = 20,
  parameter int unsigned DIR_SETUP = 50
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         cmd_valid,
  output logic [NUM_CH-1:0]         cmd_ready,
  input  logic [NUM_CH-1:0]         cmd_dir,
  input  logic [NUM_CH*COUNT_W-1:0] cmd_steps,
  input  logic [NUM_CH*HALF_W-1:0]  cmd_half,
  input  logic [NUM_CH-1:0]         abort,
  output logic [NUM_CH-1:0]         dir,
  output logic [NUM_CH-1:0]         step,
  output logic [NUM_CH-1:0]         en_n,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done
);

  localparam int unsigned SetupW = $clog2(DIR_SETUP) + 1;
  localparam int unsigned TimerW = (HALF_W > SetupW) ? HALF_W : SetupW;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow
  } state_e;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_e              state_q, state_d;
    logic [COUNT_W-1:0]  remaining_q, remaining_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                dir_q, dir_d;
    logic                step_q;
    logic                done_q, done_d;
    logic                abort_pend_q, abort_pend_d;

    logic [COUNT_W-1:0]  steps_in;
    logic [HALF_W-1:0]   half_in;
    logic [HALF_W-1:0]   half_eff;
    logic [TimerW-1:0]   half_reload;
    logic                accept;
    logic                timer_zero;

    assign steps_in    = cmd_steps[gi*COUNT_W +: COUNT_W];
    assign half_in     = cmd_half[gi*HALF_W +: HALF_W];
    assign half_eff    = (half_in == '0) ? HALF_W'(1) : half_in;
    // half_q is never 0, so the reload never underflows.
    assign half_reload = TimerW'(half_q - HALF_W'(1));
    assign accept      = cmd_valid[gi] & cmd_ready[gi];
    assign timer_zero  = (timer_q == '0);

    always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      half_d       = half_q;
      timer_d      = timer_q;
      dir_d        = dir_q;
      done_d       = 1'b0;
      abort_pend_d = abort_pend_q;
      unique case (state_q)
        StIdle: begin
          abort_pend_d = 1'b0;
          if (accept) begin
            half_d      = half_eff;
            remaining_d = steps_in;
            if (steps_in == '0) begin
              // Empty move: acknowledge without touching DIR.
              done_d = 1'b1;
            end else begin
              state_d = StSetup;
              dir_d   = cmd_dir[gi];
              timer_d = TimerW'(DIR_SETUP - 1);
            end
          end
        end
        StSetup: begin
          if (abort[gi]) begin
            state_d = StIdle;
          end else if (timer_zero) begin
            state_d = StHigh;
            timer_d = half_reload;
          end else begin
            timer_d = timer_q - TimerW'(1);
          end
        end
        StHigh: begin
          // Abort is remembered so the current high phase finishes without a runt.
          if (abort[gi]) abort_pend_d = 1'b1;
          if (timer_zero) begin
            if (abort_pend_q || abort[gi]) begin
              state_d = StIdle;
            end else begin
              state_d = StLow;
              timer_d = half_reload;
            end
          end else begin
            timer_d = timer_q - TimerW'(1);
          end
        end
        StLow: begin
          // Completion takes priority over an abort arriving on the last timeout.
          if (timer_zero && (remaining_q == COUNT_W'(1))) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (abort[gi]) begin
            state_d = StIdle;
          end else if (timer_zero) begin
            remaining_d = remaining_q - COUNT_W'(1);
            state_d     = StHigh;
            timer_d     = half_reload;
          end else begin
            timer_d = timer_q - TimerW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        state_q      <= StIdle;
        remaining_q  <= '0;
        half_q       <= HALF_W'(1);
        timer_q      <= '0;
        dir_q        <= 1'b0;
        step_q       <= 1'b0;
        done_q       <= 1'b0;
        abort_pend_q <= 1'b0;
      end else begin
        state_q      <= state_d;
        remaining_q  <= remaining_d;
        half_q       <= half_d;
        timer_q      <= timer_d;
        dir_q        <= dir_d;
        step_q       <= (state_d == StHigh);
        done_q       <= done_d;
        abort_pend_q <= abort_pend_d;
      end
    end

    assign cmd_ready[gi] = (state_q == StIdle) & ~reset;
    assign busy[gi]      = (state_q != StIdle);
    assign en_n[gi]      = (state_q == StIdle);
    assign dir[gi]       = dir_q;
    assign step[gi]      = step_q;
    assign done[gi]      = done_q;
  end

endmodule

// File: tb/tb_stepper_multi_axis.sv
// Directed bench for stepper_multi_axis with DIR_SETUP=4, NUM_CH=3.
// j = number of clock edges since (and including) the acceptance edge.
module tb_stepper_multi_axis;

  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 16;
  localparam int unsigned HW  = 20;

  logic              CLOCK_50 = 1'b0;
  logic              reset;
  logic [NCH-1:0]    cmd_valid;
  logic [NCH-1:0]    cmd_ready;
  logic [NCH-1:0]    cmd_dir;
  logic [NCH*CW-1:0] cmd_steps;
  logic [NCH*HW-1:0] cmd_half;
  logic [NCH-1:0]    abort;
  logic [NCH-1:0]    dir;
  logic [NCH-1:0]    step;
  logic [NCH-1:0]    en_n;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;

  int n_tests = 0;
  int n_fail  = 0;

  stepper_multi_axis #(
    .NUM_CH   (NCH),
    .COUNT_W  (CW),
    .HALF_W   (HW),
    .DIR_SETUP(4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_steps(cmd_steps),
    .cmd_half (cmd_half),
    .abort    (abort),
    .dir      (dir),
    .step     (step),
    .en_n     (en_n),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_cmd(input int c, input logic d, input int s, input int h);
    cmd_dir[c]            = d;
    cmd_steps[c*CW +: CW] = CW'(s);
    cmd_half[c*HW +: HW]  = HW'(h);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({dir, step, en_n, busy, done, cmd_ready} !== {3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_vals got dir=%b step=%b en_n=%b busy=%b done=%b rdy=%b want 000 000 111 000 000 000",
               dir, step, en_n, busy, done, cmd_ready);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (cmd_ready !== 3'b111) begin
      n_fail++;
      $display("FAIL ready_after_reset got %b want 111", cmd_ready);
    end
  endtask

  // ch0 dir=1 steps=3 half=5: step 5-9,15-19,25-29; busy 1-34; done 35.
  task automatic test_basic_move();
    logic [4:0] obs, exp;
    logic       s;
    set_cmd(0, 1'b1, 3, 5);
    cmd_valid[0] = 1'b1;
    for (int j = 1; j <= 37; j++) begin
      tick();
      if (j == 1) cmd_valid[0] = 1'b0;
      s   = (j >= 5 && j <= 9) || (j >= 15 && j <= 19) || (j >= 25 && j <= 29);
      exp = {1'b1, s, (j <= 34), (j == 35), !(j <= 34)};
      obs = {dir[0], step[0], busy[0], done[0], en_n[0]};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL basic_move j=%0d {dir,step,busy,done,en_n} got %b want %b", j, obs, exp);
      end
    end
  endtask

  // steps=0 leaves dir alone and strobes done once; half=0 behaves as half=1.
  task automatic test_edge_cmds();
    logic [3:0] obs, exp;
    logic       s;
    set_cmd(0, 1'b0, 0, 3);
    cmd_valid[0] = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      if (j == 1) cmd_valid[0] = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, (j == 1)};
      obs = {dir[0], step[0], busy[0], done[0]};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL zero_steps j=%0d {dir,step,busy,done} got %b want %b", j, obs, exp);
      end
    end
    set_cmd(0, 1'b0, 2, 0);
    cmd_valid[0] = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j == 1) cmd_valid[0] = 1'b0;
      s   = (j == 5) || (j == 7);
      exp = {1'b0, s, (j <= 8), (j == 9)};
      obs = {dir[0], step[0], busy[0], done[0]};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL half_zero j=%0d {dir,step,busy,done} got %b want %b", j, obs, exp);
      end
    end
  endtask

  // 10 steps, half=8; abort pulsed mid second HIGH (21-28) must not shorten it.
  task automatic test_abort_high();
    logic [4:0] obs, exp;
    logic       s, prev;
    int         rises;
    rises = 0;
    prev  = 1'b0;
    set_cmd(0, 1'b1, 10, 8);
    cmd_valid[0] = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      abort[0] = (j >= 23 && j <= 25);
      tick();
      if (j == 1) cmd_valid[0] = 1'b0;
      if (step[0] && !prev) rises++;
      prev = step[0];
      s   = (j >= 5 && j <= 12) || (j >= 21 && j <= 28);
      exp = {s, (j <= 28), 1'b0, !(j <= 28), 1'b1};
      obs = {step[0], busy[0], done[0], en_n[0], dir[0]};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL abort_high j=%0d {step,busy,done,en_n,dir} got %b want %b", j, obs, exp);
      end
    end
    abort[0] = 1'b0;
    n_tests++;
    if (rises !== 2) begin
      n_fail++;
      $display("FAIL abort_rises got %0d want 2", rises);
    end
  endtask

  // Abort held during acceptance (ignored in IDLE) and on the final LOW timeout.
  task automatic test_abort_final();
    logic [2:0] obs, exp;
    set_cmd(0, 1'b1, 1, 2);
    cmd_valid[0] = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      abort[0] = (j == 1) || (j == 9);
      tick();
      if (j == 1) cmd_valid[0] = 1'b0;
      exp = {(j == 5 || j == 6), (j <= 8), (j == 9)};
      obs = {step[0], busy[0], done[0]};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL abort_final j=%0d {step,busy,done} got %b want %b", j, obs, exp);
      end
    end
    abort[0] = 1'b0;
  endtask

  // ch1 valid held while busy; second command taken on the done cycle.
  task automatic test_back_to_back();
    logic [4:0] obs, exp;
    logic       b, s;
    set_cmd(1, 1'b1, 1, 2);
    cmd_valid[1] = 1'b1;
    for (int j = 1; j <= 21; j++) begin
      tick();
      if (j == 1) set_cmd(1, 1'b0, 1, 3);
      if (j == 10) cmd_valid[1] = 1'b0;
      b   = (j <= 8) || (j >= 10 && j <= 19);
      s   = (j == 5) || (j == 6) || (j >= 14 && j <= 16);
      exp = {!b, (j <= 9), s, b, (j == 9 || j == 20)};
      obs = {cmd_ready[1], dir[1], step[1], busy[1], done[1]};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL back_to_back j=%0d {rdy,dir,step,busy,done} got %b want %b", j, obs, exp);
      end
    end
  endtask

  // Three channels, staggered starts, different counts and periods.
  task automatic test_multi_channel();
    int   start[3]     = '{0, 2, 5};
    int   exp_rises[3] = '{2, 3, 1};
    int   exp_first[3] = '{4, 6, 9};
    int   exp_done[3]  = '{16, 18, 17};
    int   rises[3]     = '{0, 0, 0};
    int   first[3]     = '{-1, -1, -1};
    int   done_at[3]   = '{-1, -1, -1};
    int   done_cnt[3]  = '{0, 0, 0};
    logic [NCH-1:0] prev;
    prev = '0;
    set_cmd(0, 1'b1, 2, 3);
    set_cmd(1, 1'b0, 3, 2);
    set_cmd(2, 1'b1, 1, 4);
    for (int k = 0; k <= 24; k++) begin
      for (int c = 0; c < 3; c++) cmd_valid[c] = (k == start[c]);
      tick();
      for (int c = 0; c < 3; c++) begin
        if (step[c] && !prev[c]) begin
          rises[c]++;
          if (first[c] < 0) first[c] = k;
        end
        if (done[c]) begin
          done_cnt[c]++;
          done_at[c] = k;
        end
      end
      prev = step;
    end
    cmd_valid = '0;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (rises[c] !== exp_rises[c]) begin
        n_fail++;
        $display("FAIL multi_rises ch%0d got %0d want %0d", c, rises[c], exp_rises[c]);
      end
      n_tests++;
      if (first[c] !== exp_first[c]) begin
        n_fail++;
        $display("FAIL multi_first_rise ch%0d got %0d want %0d", c, first[c], exp_first[c]);
      end
      n_tests++;
      if (done_at[c] !== exp_done[c] || done_cnt[c] !== 1) begin
        n_fail++;
        $display("FAIL multi_done ch%0d got t=%0d n=%0d want t=%0d n=1", c, done_at[c],
                 done_cnt[c], exp_done[c]);
      end
    end
  endtask

  // Reset during a HIGH phase on ch2, then a normal move afterwards.
  task automatic test_reset_mid_move();
    logic [3:0] obs, exp;
    set_cmd(2, 1'b1, 5, 4);
    cmd_valid[2] = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (j == 1) cmd_valid[2] = 1'b0;
    end
    n_tests++;
    if (step[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_high got %b want 1", step[2]);
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if ({step[2], en_n[2], busy[2], done[2], cmd_ready[2], dir[2]} !== 6'b010000) begin
      n_fail++;
      $display("FAIL reset_mid_high {step,en_n,busy,done,rdy,dir} got %b want 010000",
               {step[2], en_n[2], busy[2], done[2], cmd_ready[2], dir[2]});
    end
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_tests++;
      if (done !== 3'b000 || cmd_ready !== 3'b111) begin
        n_fail++;
        $display("FAIL post_reset_idle got done=%b rdy=%b want 000 111", done, cmd_ready);
      end
    end
    set_cmd(2, 1'b1, 1, 1);
    cmd_valid[2] = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 1) cmd_valid[2] = 1'b0;
      exp = {1'b1, (j == 5), (j <= 6), (j == 7)};
      obs = {dir[2], step[2], busy[2], done[2]};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL after_reset_move j=%0d {dir,step,busy,done} got %b want %b", j, obs, exp);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = '0;
    cmd_dir   = '0;
    cmd_steps = '0;
    cmd_half  = '0;
    abort     = '0;
    test_reset();
    test_basic_move();
    test_edge_cmds();
    test_abort_high();
    test_abort_final();
    test_back_to_back();
    test_multi_channel();
    test_reset_mid_move();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stepper_multi_axis.md
# stepper_multi_axis

Parametrised multi-channel step/direction generator for A4988-class stepper drivers, the next generation of our single-axis encoder-driven stepper interface. Each channel accepts a move command over a valid/ready handshake: direction, step count and step half-period. It emits a direction setup delay, then exactly that many step pulses, then a one-cycle completion strobe. The block sits between the arm's motion sequencer and the driver pins, one channel per joint. It also provides per-channel abort and driver-enable control.

## Interface
- NUM_CH, 3, number of independent axes
- COUNT_W, 16, width of step-count field
- HALF_W, 20, width of half-period field in clock cycles
- DIR_SETUP, 50, cycles from DIR update to first STEP rising edge (1 µs @ 50 MHz); must be ≥ 1

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  NUM_CH  per-channel command valid
- cmd_ready  out  NUM_CH  per-channel command ready
- cmd_dir  in  NUM_CH  requested direction, 1 = CW, 0 = CCW
- cmd_steps  in  NUM_CH*COUNT_W  step count; channel i uses bits [i*COUNT_W +: COUNT_W]
- cmd_half  in  NUM_CH*HALF_W  half-period in cycles; channel i uses bits [i*HALF_W +: HALF_W]
- abort  in  NUM_CH  per-channel abort request, level-sensitive
- dir  out  NUM_CH  driver DIR pin
- step  out  NUM_CH  driver STEP pin, registered
- en_n  out  NUM_CH  driver ENABLE pin, active-low
- busy  out  NUM_CH  channel executing a move
- done  out  NUM_CH  one-cycle strobe on normal move completion

## Operation
- Channels are fully independent and share only clock and reset. Everything below is per channel.
- FSM states:
  - IDLE, SETUP, HIGH, LOW.
  - Internal registers: remaining (COUNT_W), half_lat (HALF_W), timer (max(HALF_W, clog2(DIR_SETUP)+1)).
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch dir, steps and half.
  - A latched half of 0 is treated as 1.
  - If steps == 0, stay in IDLE, pulse done next cycle, and leave dir unchanged.
  - Otherwise go to SETUP with dir <= cmd_dir and timer <= DIR_SETUP-1.
- SETUP:
  - Decrement timer.
  - At timer == 0, go to HIGH with timer <= half_lat-1.
- HIGH:
  - step = 1.
  - At timer == 0, go to LOW with timer <= half_lat-1.
- LOW:
  - step = 0.
  - At timer == 0 with remaining == 1, go to IDLE and set done <= 1.
  - At timer == 0 with remaining > 1, decrement remaining and go to HIGH with timer <= half_lat-1.
- busy = (state != IDLE). en_n = !busy.
- cmd_ready = (state == IDLE) & !reset. Commands presented while busy are held off and not dropped.
- Abort rules:
  - In SETUP or LOW: go to IDLE next cycle. step stays 0, done is not asserted.
  - In HIGH: the current high phase completes unchanged (no runt pulse), then go to IDLE. done is not asserted.
  - In IDLE: ignored; a command with cmd_valid in the same cycle is still accepted.
- An abort arriving on the same cycle as the final LOW timeout: normal completion wins and done pulses.
- cmd_steps, cmd_half and cmd_dir are sampled only at acceptance. Changes mid-move have no effect.

## Timing
- Reset values: dir = 0, step = 0, en_n = 1, busy = 0, done = 0, cmd_ready = 0 while reset is high. State = IDLE.
- cmd_ready rises the first cycle after reset deasserts.
- Acceptance at edge t gives:
  - t+1: busy = 1, en_n = 0, dir valid.
  - t+1+DIR_SETUP: step rises.
  - Each step: high for half cycles, low for half cycles; period = 2*half.
  - t+1+DIR_SETUP+2*half*N: state IDLE, done = 1 for exactly one cycle, cmd_ready = 1, busy = 0.
- Back-to-back commands:
  - A new command may be accepted in the same cycle done is high.
  - The next move's SETUP starts on the following cycle. Minimum low time between moves is therefore ≥ half+1+DIR_SETUP.
- dir never changes while step = 1 or during the final half-period preceding a rising step.
- Reset mid-move: on the next edge, all outputs go to reset values, including step = 0 immediately. No done is generated.

## Test plan
Bench overrides: DIR_SETUP=4, NUM_CH=3.
- Channel 0, cmd dir=1, steps=3, half=5 accepted at cycle 10 -> dir=1 at cycle 11; step high for cycles 15-19, 25-29 and 35-39; done=1 at cycle 45 only; busy high for cycles 11-44.
- steps=0 -> no step edges, busy stays 0, done=1 one cycle after acceptance; half=0 with steps=2 -> step high 1 cycle / low 1 cycle, two pulses.
- abort asserted during the 2nd HIGH phase of a 10-step, half=8 move -> that pulse is exactly 8 cycles high; IDLE afterwards; exactly 2 rising edges total; done never asserted; en_n returns to 1.
- Channel 1 cmd_valid held while busy -> cmd_ready=0 until the done cycle; the second command is accepted that cycle; the new dir appears the following cycle; the first new step follows DIR_SETUP cycles later.
- All three channels started on different cycles with different steps/half values -> independent step counts and periods match per-channel expectations; no cross-talk.
- reset asserted mid-HIGH -> step=0, en_n=1, busy=0 on the next edge; no done; a new command is accepted normally after reset.
